hoop_scene_ctrl: RTL and testbench

Frame-synchronous controller for the basketball hoop/backboard/pole renderer. Holds the current difficulty level, looks up the geometry for that level, and applies level changes only at frame boundaries so the drawn hoop never tears mid-frame. It also runs a score-flash sequence that alternates the rim colour for a fixed number of frames. It sits between game logic (level and score events) and the hoop pixel generator, which consumes its registered coordinates and rim colour.

---
 rtl/scene_pkg.sv | 45 ++++
 rtl/hoop_level_rom.sv | 19 +
 rtl/hoop_scene_ctrl.sv | 154 +++++++++++++++
 tb/tb_hoop_scene_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/scene_pkg.sv
// Shared types and constants for the hoop scene controller: colours,
// coordinate type, flash FSM states and the per-level geometry table.
package scene_pkg;

  localparam logic [11:0] RED    = 12'hF00;
  localparam logic [11:0] YELLOW = 12'hFF0;
  localparam logic [11:0] WHITE  = 12'hFFF;
  localparam logic [11:0] GRAY   = 12'h555;
  localparam logic [11:0] BLACK  = 12'h000;

  typedef logic [9:0] coord_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLASH = 1'b1
  } flash_st_e;

  // Rim, backboard and pole rectangles; the pole bottom is fixed at 479.
  typedef struct packed {
    coord_t hoop_x_l;
    coord_t hoop_x_r;
    coord_t hoop_y_t;
    coord_t hoop_y_b;
    coord_t board_x_l;
    coord_t board_x_r;
    coord_t board_y_t;
    coord_t board_y_b;
    coord_t pole_x_l;
    coord_t pole_x_r;
    coord_t pole_y_t;
  } geom_t;

  localparam logic [1:0] LVL_MAX = 2'd2;

  localparam geom_t GEOM_L0 = '{10'd620, 10'd630, 10'd97, 10'd100,
                                10'd630, 10'd633, 10'd50, 10'd100,
                                10'd630, 10'd635, 10'd50};
  localparam geom_t GEOM_L1 = '{10'd620, 10'd630, 10'd57, 10'd60,
                                10'd630, 10'd633, 10'd10, 10'd60,
                                10'd630, 10'd635, 10'd10};
  localparam geom_t GEOM_L2 = '{10'd600, 10'd610, 10'd57, 10'd60,
                                10'd610, 10'd613, 10'd10, 10'd60,
                                10'd610, 10'd615, 10'd10};

endpackage

// File: rtl/hoop_level_rom.sv
// Combinational level -> geometry lookup. Unused code 3 falls back to L0.
module hoop_level_rom
  import scene_pkg::*;
(
  input  logic [1:0] lvl,
  output geom_t      geom
);

  // Table select
  always_comb begin
    geom = GEOM_L0;
    case (lvl)
      2'd1:    geom = GEOM_L1;
      2'd2:    geom = GEOM_L2;
      default: geom = GEOM_L0;
    endcase
  end

endmodule

// File: rtl/hoop_scene_ctrl.sv
// Frame-synchronous hoop scene controller: level requests are latched and
// applied only on frame_tick so geometry never tears mid-frame; a separate
// flash FSM alternates the rim colour for FLASH_FRAMES frames after a score.
module hoop_scene_ctrl
  import scene_pkg::*;
#(
  parameter int FLASH_FRAMES = 30,
  parameter int FLASH_PERIOD = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        level_up,
  input  logic        level_clr,
  input  logic        score_evt,
  output logic [1:0]  level,
  output coord_t      hoop_x_l,
  output coord_t      hoop_x_r,
  output coord_t      hoop_y_t,
  output coord_t      hoop_y_b,
  output coord_t      board_x_l,
  output coord_t      board_x_r,
  output coord_t      board_y_t,
  output coord_t      board_y_b,
  output coord_t      pole_x_l,
  output coord_t      pole_x_r,
  output coord_t      pole_y_t,
  output logic [11:0] rim_rgb,
  output logic        flash_busy
);

  localparam logic [5:0] FRAMES_C = 6'(FLASH_FRAMES);
  localparam logic [3:0] PER_LAST = 4'(FLASH_PERIOD - 1);

  // ---------------- level path ----------------
  logic       pend_up, pend_clr;
  logic [1:0] level_q, lvl_nxt;
  geom_t      geom_q, rom_geom;
  logic       up_eff, clr_eff;

  // Requests landing on the tick cycle count as if already pending
  always_comb begin
    up_eff  = pend_up | level_up;
    clr_eff = pend_clr | level_clr;
    lvl_nxt = level_q;
    if (frame_tick) begin
      if (clr_eff)                           lvl_nxt = 2'd0;
      else if (up_eff && level_q != LVL_MAX) lvl_nxt = level_q + 2'd1;
    end
  end

  // The ROM looks at the next level so geometry lands with the level itself
  hoop_level_rom u_rom (
    .lvl  (lvl_nxt),
    .geom (rom_geom)
  );

  // Pending flags, applied level and registered geometry
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_up  <= 1'b0;
      pend_clr <= 1'b0;
      level_q  <= 2'd0;
      geom_q   <= GEOM_L0;
    end else if (frame_tick) begin
      pend_up  <= 1'b0;
      pend_clr <= 1'b0;
      level_q  <= lvl_nxt;
      geom_q   <= rom_geom;
    end else begin
      pend_up  <= up_eff;
      pend_clr <= clr_eff;
    end
  end

  assign level     = level_q;
  assign hoop_x_l  = geom_q.hoop_x_l;
  assign hoop_x_r  = geom_q.hoop_x_r;
  assign hoop_y_t  = geom_q.hoop_y_t;
  assign hoop_y_b  = geom_q.hoop_y_b;
  assign board_x_l = geom_q.board_x_l;
  assign board_x_r = geom_q.board_x_r;
  assign board_y_t = geom_q.board_y_t;
  assign board_y_b = geom_q.board_y_b;
  assign pole_x_l  = geom_q.pole_x_l;
  assign pole_x_r  = geom_q.pole_x_r;
  assign pole_y_t  = geom_q.pole_y_t;

  // ---------------- flash FSM ----------------
  flash_st_e  st_q, st_nxt;
  logic [5:0] fcnt_q, fcnt_nxt;
  logic [3:0] pcnt_q, pcnt_nxt;
  logic       ph_q, ph_nxt;

  // State and counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q   <= S_IDLE;
      fcnt_q <= 6'd0;
      pcnt_q <= 4'd0;
      ph_q   <= 1'b0;
    end else begin
      st_q   <= st_nxt;
      fcnt_q <= fcnt_nxt;
      pcnt_q <= pcnt_nxt;
      ph_q   <= ph_nxt;
    end
  end

  // Next state and Moore outputs; a score restart beats a coincident tick
  always_comb begin
    st_nxt     = st_q;
    fcnt_nxt   = fcnt_q;
    pcnt_nxt   = pcnt_q;
    ph_nxt     = ph_q;
    rim_rgb    = RED;
    flash_busy = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (score_evt) begin
          st_nxt   = S_FLASH;
          fcnt_nxt = 6'd0;
          pcnt_nxt = 4'd0;
          ph_nxt   = 1'b0;
        end
      end
      S_FLASH: begin
        flash_busy = 1'b1;
        rim_rgb    = ph_q ? RED : YELLOW;
        if (score_evt) begin
          fcnt_nxt = 6'd0;
          pcnt_nxt = 4'd0;
          ph_nxt   = 1'b0;
        end else if (frame_tick) begin
          fcnt_nxt = fcnt_q + 6'd1;
          if (pcnt_q == PER_LAST) begin
            pcnt_nxt = 4'd0;
            ph_nxt   = ~ph_q;
          end else begin
            pcnt_nxt = pcnt_q + 4'd1;
          end
          if (fcnt_q + 6'd1 == FRAMES_C) begin
            st_nxt   = S_IDLE;
            fcnt_nxt = 6'd0;
            pcnt_nxt = 4'd0;
            ph_nxt   = 1'b0;
          end
        end
      end
      default: st_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hoop_scene_ctrl.sv
// Directed bench for hoop_scene_ctrl with hand-computed expectations.
module tb_hoop_scene_ctrl;

  logic        clk = 1'b0;
  logic        reset_n, frame_tick, level_up, level_clr, score_evt;
  logic [1:0]  level;
  logic [9:0]  hoop_x_l, hoop_x_r, hoop_y_t, hoop_y_b;
  logic [9:0]  board_x_l, board_x_r, board_y_t, board_y_b;
  logic [9:0]  pole_x_l, pole_x_r, pole_y_t;
  logic [11:0] rim_rgb;
  logic        flash_busy;

  int n_chk  = 0;
  int n_fail = 0;

  hoop_scene_ctrl #(.FLASH_FRAMES(30), .FLASH_PERIOD(4)) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .level_up(level_up), .level_clr(level_clr), .score_evt(score_evt),
    .level(level),
    .hoop_x_l(hoop_x_l), .hoop_x_r(hoop_x_r), .hoop_y_t(hoop_y_t), .hoop_y_b(hoop_y_b),
    .board_x_l(board_x_l), .board_x_r(board_x_r), .board_y_t(board_y_t), .board_y_b(board_y_b),
    .pole_x_l(pole_x_l), .pole_x_r(pole_x_r), .pole_y_t(pole_y_t),
    .rim_rgb(rim_rgb), .flash_busy(flash_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, leaving time 1 unit after the last edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame tick followed by a short gap so ticks stay one-cycle pulses
  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic tick_gap();
    tick();
    step(2);
  endtask

  task automatic pulse_up();
    level_up = 1'b1; step(1); level_up = 1'b0; step(1);
  endtask

  task automatic pulse_score();
    score_evt = 1'b1; step(1); score_evt = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; frame_tick = 1'b0; level_up = 1'b0;
    level_clr = 1'b0; score_evt = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(1);

    // Reset state
    chk("rst_level", level, 0);
    chk("rst_hoop_x_l", hoop_x_l, 620);
    chk("rst_hoop_x_r", hoop_x_r, 630);
    chk("rst_hoop_y_t", hoop_y_t, 97);
    chk("rst_hoop_y_b", hoop_y_b, 100);
    chk("rst_board_x_r", board_x_r, 633);
    chk("rst_pole_x_r", pole_x_r, 635);
    chk("rst_pole_y_t", pole_y_t, 50);
    chk("rst_rim", rim_rgb, 12'hF00);
    chk("rst_busy", flash_busy, 0);

    // Idle three frames
    for (int f = 0; f < 3; f++) begin step(20); tick(); end
    chk("idle_level", level, 0);
    chk("idle_hoop_y_t", hoop_y_t, 97);

    // level_up mid-frame, tick 100 clocks later
    pulse_up();
    step(98);
    chk("pend_level_hold", level, 0);
    chk("pend_hoop_y_t_hold", hoop_y_t, 97);
    tick();
    chk("l1_level", level, 1);
    chk("l1_hoop_y_t", hoop_y_t, 57);
    chk("l1_board_y_t", board_y_t, 10);
    chk("l1_pole_y_t", pole_y_t, 10);
    chk("l1_hoop_x_l", hoop_x_l, 620);

    // Three requests in a frame collapse to one step
    pulse_up(); pulse_up(); pulse_up();
    tick_gap();
    chk("collapse_level", level, 2);
    chk("l2_hoop_x_l", hoop_x_l, 600);
    chk("l2_board_x_l", board_x_l, 610);
    chk("l2_pole_x_r", pole_x_r, 615);

    // Saturate at level 2
    pulse_up(); pulse_up(); pulse_up();
    tick_gap();
    chk("sat_level", level, 2);
    chk("sat_hoop_x_l", hoop_x_l, 600);

    // Clear wins over up in the same frame
    pulse_up();
    level_clr = 1'b1; step(1); level_clr = 1'b0; step(5);
    tick_gap();
    chk("clr_level", level, 0);
    chk("clr_board_y_t", board_y_t, 50);
    chk("clr_hoop_x_l", hoop_x_l, 620);

    // Request coincident with tick is applied at that tick
    level_up = 1'b1; frame_tick = 1'b1; step(1);
    level_up = 1'b0; frame_tick = 1'b0;
    chk("coinc_up_level", level, 1);
    step(3);
    tick_gap();
    chk("coinc_no_carry", level, 1);
    level_clr = 1'b1; frame_tick = 1'b1; step(1);
    level_clr = 1'b0; frame_tick = 1'b0;
    chk("coinc_clr_level", level, 0);
    step(3);

    // Full flash: FF0 for ticks 0..3, F00 for 4..7, ...; idle after tick 30
    pulse_score();
    chk("flash_start_busy", flash_busy, 1);
    chk("flash_start_rim", rim_rgb, 12'hFF0);
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (t == 30) begin
        chk("flash_end_busy", flash_busy, 0);
        chk("flash_end_rim", rim_rgb, 12'hF00);
      end else begin
        chk("flash_busy", flash_busy, 1);
        chk("flash_rim", rim_rgb, (((t / 4) % 2) == 0) ? 12'hFF0 : 12'hF00);
      end
      if (t == 10) begin
        level_up = 1'b1; step(1); level_up = 1'b0;
      end
      step(2);
    end
    chk("flash_lvl_indep", level, 1);

    // Restart coincident with tick 20
    pulse_score();
    step(2);
    for (int t = 1; t <= 20; t++) tick_gap();
    chk("pre_restart_rim", rim_rgb, 12'hF00);
    score_evt = 1'b1; frame_tick = 1'b1; step(1);
    score_evt = 1'b0; frame_tick = 1'b0;
    chk("restart_rim", rim_rgb, 12'hFF0);
    chk("restart_busy", flash_busy, 1);
    step(2);
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (t == 3)  chk("rs_t3_rim", rim_rgb, 12'hFF0);
      if (t == 4)  chk("rs_t4_rim", rim_rgb, 12'hF00);
      if (t == 29) chk("rs_t29_busy", flash_busy, 1);
      if (t == 30) chk("rs_t30_busy", flash_busy, 0);
      step(2);
    end

    // Reset mid-flash with a pending request
    pulse_score();
    for (int t = 1; t <= 5; t++) tick_gap();
    pulse_up();
    chk("pre_rst_busy", flash_busy, 1);
    reset_n = 1'b0; step(1);
    chk("mid_rst_rim", rim_rgb, 12'hF00);
    chk("mid_rst_busy", flash_busy, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_hoop_y_t", hoop_y_t, 97);
    reset_n = 1'b1; step(2);
    tick_gap();
    chk("rst_pend_dropped", level, 0);
    chk("rst_idle_busy", flash_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Backstop so a stuck run still terminates
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
